// File: rtl/image_packer.sv
// Raster-order pixel packer: collects ROWS x COLS pixels into a flat frame bus.
// The frame is then held with image_valid high until the consumer acknowledges it.
module image_packer #(
   parameter int ROWS = 4,
   parameter int COLS = 5,
   parameter int PW   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PW-1:0]            pix_in,
   input  logic                     pix_valid,
   input  logic                     pix_sof,
   output logic                     pix_ready,
   output logic [0:ROWS*COLS*PW-1]  image,
   output logic                     image_valid,
   input  logic                     image_ack,
   output logic                     sof_err
);

   localparam int N     = ROWS * COLS;
   localparam int IMG_W = N * PW;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int SW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

   typedef enum logic {
      FILL,
      HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [RW-1:0]    row_q, row_d;
   logic [CW-1:0]    col_q, col_d;
   logic [0:IMG_W-1] image_q, image_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic [RW-1:0]    wr_row;
   logic [CW-1:0]    wr_col;
   logic [SW-1:0]    wr_slot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         row_q   <= '0;
         col_q   <= '0;
         image_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         image_q <= image_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      image_d = image_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      wr_row  = row_q;
      wr_col  = col_q;
      wr_slot = '0;

      unique case (state_q)
         FILL: begin
            if (pix_valid) begin
               // A start-of-frame pixel is written as slot (0,0), then counting resumes normally.
               if (pix_sof) begin
                  wr_row = '0;
                  wr_col = '0;
                  err_d  = (row_q != '0) || (col_q != '0);
               end
               wr_slot = SW'(wr_row) * SW'(COLS) + SW'(wr_col);
               for (int unsigned s = 0; s < N; s++) begin
                  if (s == 32'(wr_slot)) begin
                     image_d[s*PW +: PW] = pix_in;
                  end
               end
               if (wr_col == LAST_COL) begin
                  col_d = '0;
                  if (wr_row == LAST_ROW) begin
                     row_d   = '0;
                     state_d = HOLD;
                     valid_d = 1'b1;
                  end else begin
                     row_d = wr_row + RW'(1);
                  end
               end else begin
                  col_d = wr_col + CW'(1);
                  row_d = wr_row;
               end
            end
         end
         HOLD: begin
            if (image_ack) begin
               state_d = FILL;
               valid_d = 1'b0;
            end
         end
      endcase
   end

   assign pix_ready   = (state_q == FILL);
   assign image       = image_q;
   assign image_valid = valid_q;
   assign sof_err     = err_q;

endmodule

// File: tb/tb_image_packer.sv
// Randomized bench for image_packer against a linear-index frame model.
module tb_image_packer;

   localparam int ROWS  = 4;
   localparam int COLS  = 5;
   localparam int PW    = 8;
   localparam int N     = ROWS * COLS;
   localparam int IMG_W = N * PW;

   logic             clk = 1'b0;
   logic             rst;
   logic [PW-1:0]    pix_in;
   logic             pix_valid;
   logic             pix_sof;
   logic             pix_ready;
   logic [0:IMG_W-1] image;
   logic             image_valid;
   logic             image_ack;
   logic             sof_err;

   always #5 clk = ~clk;

   image_packer #(.ROWS(ROWS), .COLS(COLS), .PW(PW)) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_in      (pix_in),
      .pix_valid   (pix_valid),
      .pix_sof     (pix_sof),
      .pix_ready   (pix_ready),
      .image       (image),
      .image_valid (image_valid),
      .image_ack   (image_ack),
      .sof_err     (sof_err)
   );

   int errors = 0;
   int checks = 0;

   // Reference: frame as an array indexed by raster position, one fill pointer.
   logic [PW-1:0] m_frame [N];
   int            m_pos;
   bit            m_hold;
   bit            m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_frame[i] = '0;
      m_pos  = 0;
      m_hold = 0;
      m_err  = 0;
   endtask

   task automatic model_edge();
      m_err = 0;
      if (!m_hold) begin
         if (pix_valid) begin
            if (pix_sof) begin
               if (m_pos != 0) m_err = 1;
               m_pos = 0;
            end
            m_frame[m_pos] = pix_in;
            m_pos++;
            if (m_pos == N) begin
               m_pos  = 0;
               m_hold = 1;
            end
         end
      end else if (image_ack) begin
         m_hold = 0;
      end
   endtask

   task automatic compare_all();
      check("pix_ready", 32'(pix_ready), 32'(!m_hold));
      check("image_valid", 32'(image_valid), 32'(m_hold));
      check("sof_err", 32'(sof_err), 32'(m_err));
      if (m_hold) begin
         for (int i = 0; i < N; i++) begin
            check($sformatf("slot%0d", i), 32'(image[i*PW +: PW]), 32'(m_frame[i]));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   // Offer one pixel until accepted; gap=1 inserts random idle cycles carrying junk data.
   task automatic push(input logic [PW-1:0] val, input bit sof, input bit gap);
      bit acc;
      acc = 0;
      for (int t = 0; t < 50 && !acc; t++) begin
         pix_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
         pix_in    = pix_valid ? val : PW'($urandom);
         pix_sof   = pix_valid ? sof : 1'($urandom);
         acc       = pix_valid && !m_hold;
         tick();
      end
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      check("push_accepted", 32'(acc), 32'd1);
   endtask

   task automatic ack_pulse();
      image_ack = 1'b1;
      tick();
      image_ack = 1'b0;
   endtask

   task automatic async_reset_check(input string tag);
      #1 rst = 1'b1;
      #1;
      model_reset();
      check({tag, "_ready"}, 32'(pix_ready), 32'd1);
      check({tag, "_valid"}, 32'(image_valid), 32'd0);
      check({tag, "_zero"}, 32'(image == '0), 32'd1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      pix_in    = '0;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      image_ack = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(pix_ready), 32'd1);
      check("rst_valid", 32'(image_valid), 32'd0);
      check("rst_err", 32'(sof_err), 32'd0);
      check("rst_zero", 32'(image == '0), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back frame 0x01..0x14
      for (int i = 0; i < N; i++) push(PW'(i + 1), i == 0, 1'b0);
      check("s1_px00", 32'(image[0:7]), 32'h01);
      check("s1_px05", 32'(image[32:39]), 32'h05);
      check("s1_px06", 32'(image[40:47]), 32'h06);
      check("s1_px19", 32'(image[152:159]), 32'h14);
      check("s1_ready", 32'(pix_ready), 32'd0);

      // Long hold with junk offered, then ack
      pix_valid = 1'b1;
      pix_in    = 8'hFF;
      repeat (10) tick();
      pix_valid = 1'b0;
      ack_pulse();
      check("s2_ready", 32'(pix_ready), 32'd1);

      // Same frame with random gaps
      for (int i = 0; i < N; i++) push(PW'(i + 1), i == 0, 1'b1);
      check("s3_px19", 32'(image[152:159]), 32'h14);
      repeat (3) tick();
      ack_pulse();

      // Restart mid-frame with sof
      for (int i = 0; i < 7; i++) push(PW'($urandom), i == 0, 1'b0);
      push(8'hA0, 1'b1, 1'b0);
      check("s4_sof_err", 32'(sof_err), 32'd1);
      for (int i = 1; i < N; i++) begin
         push(PW'(8'hA0 + i), 1'b0, 1'b1);
         if (i < N - 1) check("s4_no_valid", 32'(image_valid), 32'd0);
      end
      check("s4_px00", 32'(image[0:7]), 32'hA0);
      check("s4_px19", 32'(image[152:159]), 32'hB3);
      ack_pulse();

      // Reset mid-frame and during hold
      for (int i = 0; i < 12; i++) push(PW'($urandom), i == 0, 1'b0);
      async_reset_check("s5_mid");
      for (int i = 0; i < N; i++) push(PW'($urandom), 1'b0, 1'b1);
      tick();
      async_reset_check("s5_hold");
      for (int i = 0; i < N; i++) push(PW'($urandom), 1'b0, 1'b0);
      ack_pulse();

      // Ack held during fill, sof exactly at slot (0,0)
      image_ack = 1'b1;
      for (int i = 0; i < N - 1; i++) push(PW'($urandom), i == 0, 1'b1);
      image_ack = 1'b0;
      push(PW'($urandom), 1'b0, 1'b0);
      check("s6_valid", 32'(image_valid), 32'd1);
      repeat (2) tick();
      ack_pulse();

      // Random traffic with occasional sof and random ack delays
      for (int k = 0; k < 120; k++) begin
         if (m_hold) begin
            repeat ($urandom_range(0, 3)) tick();
            ack_pulse();
         end else begin
            push(PW'($urandom), $urandom_range(0, 9) == 0, 1'b1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
